// File: rtl/tc_sram_adapter_pkg.sv
// Shared widths, width helpers and the request bundle used around the
// tc_sram stream adapter.
package tc_sram_adapter_pkg;

    localparam int unsigned DefNumWords  = 1024;
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefByteWidth = 8;

    // Address width is max(1, clog2(NumWords)).
    function automatic int unsigned calc_addr_width(
        input int unsigned num_words
    );
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    // One byte-enable lane per ByteWidth bits, rounded up.
    function automatic int unsigned calc_be_width(
        input int unsigned data_width,
        input int unsigned byte_width
    );
        return (data_width + byte_width - 1) / byte_width;
    endfunction

    localparam int unsigned DefAddrWidth = calc_addr_width(DefNumWords);
    localparam int unsigned DefBeWidth   =
        calc_be_width(DefDataWidth, DefByteWidth);

    // Request bundle, sized by the package defaults.
    typedef struct packed {
        logic                    we;
        logic [DefAddrWidth-1:0] addr;
        logic [DefDataWidth-1:0] wdata;
        logic [DefBeWidth-1:0]   be;
    } sram_req_t;

endpackage

// File: rtl/tc_sram_rsp_fifo.sv
// Response FIFO, first-word not fall-through, sync active-high reset.
// Ports: push_i/data_i write side, pop_i/data_o read side, full_o, empty_o.
module tc_sram_rsp_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_cnt;

    logic            w_push;
    logic            w_pop;
    logic [PtrW-1:0] w_wptr_nxt;
    logic [PtrW-1:0] w_rptr_nxt;

    assign full_o  = (r_cnt == CntW'(Depth));
    assign empty_o = (r_cnt == '0);
    assign data_o  = r_mem[r_rptr];

    // A push into a full FIFO is only taken when a pop frees the slot.
    assign w_push = push_i && (!full_o || pop_i);
    assign w_pop  = pop_i && !empty_o;

    assign w_wptr_nxt = (r_wptr == PtrW'(Depth - 1)) ? '0
                                                      : r_wptr + PtrW'(1);
    assign w_rptr_nxt = (r_rptr == PtrW'(Depth - 1)) ? '0
                                                      : r_rptr + PtrW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= w_wptr_nxt;
            if (w_pop)  r_rptr <= w_rptr_nxt;
            r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/tc_sram_stream_adapter.sv
// Valid/ready request stream to single-port tc_sram, with credit-throttled
// read tracking and a buffered response stream (req_*, rsp_*, sram_*).
module tc_sram_stream_adapter
    import tc_sram_adapter_pkg::*;
#(
    parameter  int unsigned NumWords  = 1024,
    parameter  int unsigned DataWidth = 32,
    parameter  int unsigned ByteWidth = 8,
    parameter  int unsigned Latency   = 1,
    parameter  int unsigned RspDepth  = 2,
    localparam int unsigned AddrWidth = calc_addr_width(NumWords),
    localparam int unsigned BeWidth   = calc_be_width(DataWidth, ByteWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    if (Latency < 1) begin : g_bad_latency
        $error("tc_sram_stream_adapter: Latency must be >= 1");
    end
    if (RspDepth < 1) begin : g_bad_depth
        $error("tc_sram_stream_adapter: RspDepth must be >= 1");
    end

    localparam int unsigned CntW = $clog2(RspDepth + 1);

    // r_cnt = reads in flight + FIFO occupancy.
    logic [CntW-1:0]    r_cnt;
    logic [Latency-1:0] r_vld;

    logic                 w_fire;
    logic                 w_rd_fire;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [Latency-1:0]   w_vld_d;
    logic [DataWidth-1:0] w_head;

    // Ready depends on state only. A read holds its credit from acceptance
    // until it is popped, so the FIFO can never overflow.
    assign req_ready_o = !rst_i && (r_cnt < CntW'(RspDepth));
    assign w_fire      = req_valid_i && req_ready_o;
    assign w_rd_fire   = w_fire && !req_we_i;

    assign sram_req_o   = w_fire;
    assign sram_we_o    = w_fire && req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = w_fire ? req_be_i : '0;

    assign w_vld_d = (r_vld << 1) | Latency'(w_rd_fire);
    assign w_push  = r_vld[Latency-1];

    assign rsp_valid_o = !rst_i && !w_empty;
    assign rsp_rdata_o = w_head;
    assign w_pop       = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_vld <= '0;
        end else begin
            r_cnt <= r_cnt + CntW'(w_rd_fire) - CntW'(w_pop);
            r_vld <= w_vld_d;
        end
    end

    tc_sram_rsp_fifo #(
        .Depth (RspDepth),
        .Width (DataWidth)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (sram_rdata_i),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    a_push_room: assert property (@(posedge clk_i) disable iff (rst_i)
        w_push |-> (!w_full || w_pop));

    a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i)
        r_cnt <= CntW'(RspDepth));

    a_cnt_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_rd_fire && !w_pop && r_cnt == CntW'(RspDepth)));

    a_cnt_udf: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_pop && !w_rd_fire && r_cnt == '0));

    a_rsp_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (rsp_valid_o && !rsp_ready_i) |=> $stable(rsp_rdata_o));

endmodule

// File: tb/tb_tc_sram_stream_adapter.sv
// Scoreboard bench for tc_sram_stream_adapter with a behavioural SRAM.
// Stimulus pushes expected read data; a negedge monitor pops and compares.
module tb_tc_sram_stream_adapter;
    import tc_sram_adapter_pkg::*;

    localparam int L  = 1;
    localparam int D  = 3;
    localparam int AW = DefAddrWidth;
    localparam int DW = DefDataWidth;
    localparam int BW = DefBeWidth;

    logic          clk;
    logic          rst;
    logic          req_valid;
    sram_req_t     rq;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          sram_req;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [BW-1:0] sram_be;
    logic [DW-1:0] sram_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int outst = 0;
    logic [31:0] exp_q[$];
    logic [31:0] shadow [16];
    logic [31:0] mem [DefNumWords];
    logic [31:0] rd_pipe [L];
    logic        hold_q = 1'b0;
    logic [31:0] hold_d = '0;

    tc_sram_stream_adapter #(
        .NumWords  (DefNumWords),
        .DataWidth (DefDataWidth),
        .ByteWidth (DefByteWidth),
        .Latency   (L),
        .RspDepth  (D)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (rq.we),
        .req_addr_i   (rq.addr),
        .req_wdata_i  (rq.wdata),
        .req_be_i     (rq.be),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_be_o    (sram_be),
        .sram_rdata_i (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port SRAM with L-cycle read latency.
    assign sram_rdata = rd_pipe[L-1];
    always @(posedge clk) begin
        if (sram_req && sram_we) begin
            for (int b = 0; b < BW; b++)
                if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
        if (sram_req && !sram_we) rd_pipe[0] <= mem[sram_addr];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: protocol model, credit model and scoreboard pop.
    always @(negedge clk) begin
        logic pop;
        chk("req_ready", req_ready, !rst && (outst < D));
        chk("sram_req", sram_req, req_valid && req_ready);
        if (!sram_req) chk("sram_idle_we_be", {sram_we, sram_be}, '0);
        else chk("sram_addr", sram_addr, rq.addr);
        if (rst) begin
            chk("rsp_valid_in_rst", rsp_valid, 1'b0);
            outst = 0;
            hold_q = 1'b0;
        end else begin
            pop = rsp_valid && rsp_ready;
            if (hold_q && rsp_valid) chk("rsp_hold", rsp_rdata, hold_d);
            hold_q = rsp_valid && !rsp_ready;
            hold_d = rsp_rdata;
            if (rsp_valid && exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got %0h expected no response",
                         rsp_rdata);
            end else if (pop) begin
                chk("rdata", rsp_rdata, exp_q.pop_front());
            end
            outst = outst + int'(req_valid && req_ready && !rq.we) - int'(pop);
            chk("credit_range", outst <= D, 1'b1);
        end
    end

    task automatic shadow_wr(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
    endtask

    // Present one request and hold it until accepted; leaves valid high.
    task automatic issue(input logic we, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] exp, output int acc_cyc);
        bit ok = 0;
        rq.we = we; rq.addr = a; rq.wdata = wd; rq.be = be;
        req_valid = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                acc_cyc = cyc;
                if (!we) exp_q.push_back(exp);
                else if (a < 16) shadow_wr(a[3:0], wd, be);
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got no accept expected accept addr %0h", a);
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); #1;
            done = (exp_q.size() == 0) && (outst == 0);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got %0d pending expected 0", name,
                     exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int acc;
        int n_acc;
        bit seen;
        for (int i = 0; i < DefNumWords; i++) mem[i] = '0;
        for (int i = 0; i < L; i++) rd_pipe[i] = '0;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; rq = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single write then read, latency L+1 to rsp_valid.
        issue(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 32'h0, acc);
        issue(1'b0, 10'd5, 32'h0, 4'h0, 32'hDEADBEEF, acc);
        req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        chk("rd_latency", cyc - acc, L + 1);
        @(posedge clk); #1;
        wait_drain("single");

        // Byte enables: 0xFFFFFFFF then 0 on lanes 0 and 2.
        issue(1'b1, 10'd3, 32'hFFFFFFFF, 4'hF, 32'h0, acc);
        issue(1'b1, 10'd3, 32'h00000000, 4'h5, 32'h0, acc);
        issue(1'b0, 10'd3, 32'h0, 4'h0, 32'hFF00FF00, acc);
        req_valid = 1'b0;
        wait_drain("byte_en");

        for (int i = 0; i < 5; i++)
            issue(1'b1, AW'(i), 32'hA5A50000 | i, 4'hF, 32'h0, acc);
        req_valid = 1'b0;

        // Backpressure: only D reads fit while the consumer stalls.
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            rq = '0; rq.addr = AW'(n_acc); req_valid = 1'b1;
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(32'hA5A50000 | n_acc);
                n_acc++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("bp_accepted", n_acc, D);
        @(negedge clk);
        chk("bp_ready_low", req_ready, 1'b0);
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = n_acc; i < 5; i++)
            issue(1'b0, AW'(i), 32'h0, 4'h0, 32'hA5A50000 | i, acc);
        req_valid = 1'b0;
        wait_drain("backpressure");

        // Throughput: 16 back-to-back reads, responses every cycle.
        for (int k = 0; k < 18; k++) begin
            req_valid = (k < 16);
            rq = '0; rq.addr = AW'(k % 5);
            @(negedge clk);
            if (k < 16) begin
                chk("tp_ready", req_ready, 1'b1);
                if (req_ready) exp_q.push_back(32'hA5A50000 | (k % 5));
            end
            if (k >= L + 1) chk("tp_rsp_valid", rsp_valid, 1'b1);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        wait_drain("throughput");

        // Mid-operation reset: two buffered, one in flight.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            issue(1'b0, AW'(i), 32'h0, 4'h0, 32'hA5A50000 | i, acc);
        req_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", rsp_valid, 1'b0);
            chk("post_rst_ready", req_ready, 1'b1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        issue(1'b0, 10'd4, 32'h0, 4'h0, 32'hA5A50004, acc);
        req_valid = 1'b0;
        wait_drain("mid_reset");

        // Random traffic against the shadow model.
        for (int i = 0; i < 16; i++)
            issue(1'b1, AW'(i), 32'h5A000000 | (i * 32'h01010101), 4'hF,
                  32'h0, acc);
        req_valid = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            logic hit;
            if (!req_valid && $urandom_range(0, 9) < 6) begin
                rq.we    = ($urandom_range(0, 2) == 0);
                rq.addr  = AW'($urandom_range(0, 15));
                rq.wdata = $urandom;
                rq.be    = 4'($urandom_range(0, 15));
                req_valid = 1'b1;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hit = req_valid && req_ready;
            if (hit) begin
                if (rq.we) shadow_wr(rq.addr[3:0], rq.wdata, rq.be);
                else exp_q.push_back(shadow[rq.addr[3:0]]);
            end
            @(posedge clk); #1;
            if (hit) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
